comp_mult_acc: RTL and testbench

Downstream stage of the complex multiplier. Consumes the multiplier result stream {xr, yr} over a val-rdy interface. Accumulates a programmable number of consecutive complex products, one frame at a time. Emits the complex sum (a complex dot product) on an output val-rdy interface.

---
 rtl/comp_mult_acc.sv | 109 ++++++++++
 tb/tb_comp_mult_acc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_mult_acc.sv
// Complex multiply-accumulate stage: sums cfg_len consecutive {xr, yr} products
// per frame and presents the complex sum on a val-rdy output.
module comp_mult_acc #(
  parameter int DWIDTH = 8,
  parameter int LEN_W  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  sw_rst,
  input  logic [LEN_W-1:0]                      cfg_len,
  input  logic                                  res_val,
  output logic                                  res_rdy,
  input  logic [4*(DWIDTH+1)-1:0]               res_data,
  output logic                                  acc_val,
  input  logic                                  acc_rdy,
  output logic [2*(2*(DWIDTH+1)+LEN_W)-1:0]     acc_data,
  output logic                                  acc_busy
);

  localparam int RW = 2*(DWIDTH+1);
  localparam int AW = RW + LEN_W;

  typedef enum logic {ACC, OUT} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [AW-1:0]     xa_q, xa_d;
  logic [AW-1:0]     ya_q, ya_d;
  logic [2*AW-1:0]   out_q, out_d;

  logic [RW-1:0]     xr, yr;
  logic [AW-1:0]     xs, ys, x_sum, y_sum;
  logic [LEN_W-1:0]  eff_len;
  logic              first, last;

  always_comb begin
    xr      = res_data[2*RW-1:RW];
    yr      = res_data[RW-1:0];
    xs      = {{LEN_W{xr[RW-1]}}, xr};
    ys      = {{LEN_W{yr[RW-1]}}, yr};
    first   = (cnt_q == '0);
    // Frame length is sampled only on the first item; later cfg_len edits wait for the next frame.
    eff_len = first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
    x_sum   = first ? xs : (xa_q + xs);
    y_sum   = first ? ys : (ya_q + ys);
    last    = ({1'b0, cnt_q} + (LEN_W+1)'(1)) == {1'b0, eff_len};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    out_d   = out_q;
    unique case (state_q)
      ACC: begin
        if (res_val) begin
          xa_d = x_sum;
          ya_d = y_sum;
          if (first) len_d = eff_len;
          if (last) begin
            cnt_d   = '0;
            state_d = OUT;
            out_d   = {x_sum, y_sum};
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      OUT: begin
        if (acc_rdy) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      len_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      out_q   <= '0;
    end else if (sw_rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      len_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      out_q   <= out_d;
    end
  end

  assign res_rdy  = (state_q == ACC);
  assign acc_val  = (state_q == OUT);
  assign acc_data = out_q;
  assign acc_busy = (cnt_q != '0);

endmodule

// File: tb/tb_comp_mult_acc.sv
// Scoreboard bench for comp_mult_acc: a frame-level reference model queues
// expected sums; an independent monitor compares each output handshake.
module tb_comp_mult_acc;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int RW = 2*(DW+1);
  localparam int AW = RW + LW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sw_rst = 1'b0;
  logic [LW-1:0]     cfg_len = 8'd1;
  logic              res_val = 1'b0;
  logic              res_rdy;
  logic [2*RW-1:0]   res_data = '0;
  logic              acc_val;
  logic              acc_rdy = 1'b0;
  logic [2*AW-1:0]   acc_data;
  logic              acc_busy;

  comp_mult_acc #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .cfg_len(cfg_len),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
    .acc_val(acc_val), .acc_rdy(acc_rdy), .acc_data(acc_data),
    .acc_busy(acc_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [2*AW-1:0] exp_q[$];
  longint fx[$];
  longint fy[$];
  int cur_len = 1;
  bit sink_rand = 1'b0;
  bit sink_force = 1'b1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: collect a frame's items, sum with plain integers when it is complete.
  function automatic void model_accept(longint x, longint y);
    longint sx, sy;
    logic [AW-1:0] tx, ty;
    if (fx.size() == 0) cur_len = (cfg_len == 0) ? 1 : int'(cfg_len);
    fx.push_back(x);
    fy.push_back(y);
    if (fx.size() == cur_len) begin
      sx = 0; sy = 0;
      foreach (fx[i]) begin sx += fx[i]; sy += fy[i]; end
      tx = AW'(sx);
      ty = AW'(sy);
      exp_q.push_back({tx, ty});
      fx.delete();
      fy.delete();
    end
  endfunction

  task automatic send(input int x, input int y, input int gap);
    bit done = 1'b0;
    logic [RW-1:0] dx, dy;
    if (gap > 0) begin
      res_val = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    dx = RW'(x);
    dy = RW'(y);
    res_data = {dx, dy};
    res_val = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (res_rdy) begin
        model_accept(longint'(x), longint'(y));
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got res_rdy=0 for 300 cycles expected acceptance");
    end
  endtask

  task automatic idle();
    res_val = 1'b0;
  endtask

  task automatic do_swrst();
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    fx.delete();
    fy.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      acc_rdy = sink_rand ? 1'($urandom_range(0, 1)) : sink_force;
    end
  end

  // Monitor: every output handshake pops one expected sum.
  initial begin
    logic [2*AW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !sw_rst && acc_val && acc_rdy) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: got 0x%0h expected no output", acc_data);
        end else begin
          e = exp_q.pop_front();
          check("acc_data", 64'(acc_data), 64'(e));
        end
        @(posedge clk); #1;
        check("rdy_after_out", {62'd0, res_rdy, acc_val}, 64'b10);
      end
    end
  end

  initial begin
    logic [2*AW-1:0] prev = '0;
    bit stall = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && acc_val) check("hold_data", 64'(acc_data), 64'(prev));
      stall = rst_n && !sw_rst && acc_val && !acc_rdy;
      prev  = acc_data;
    end
  end

  initial begin
    logic [2*AW-1:0] held;
    int n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_rdy", 64'(res_rdy), 64'd1);
    check("reset_val", 64'(acc_val), 64'd0);
    check("reset_data", 64'(acc_data), 64'd0);
    check("reset_busy", 64'(acc_busy), 64'd0);

    // Single-item frame.
    sink_force = 1'b1;
    @(posedge clk); #1;
    cfg_len = 8'd1;
    send(100, -50, 0);
    idle();
    check("len1_val", 64'(acc_val), 64'd1);
    repeat (3) begin @(posedge clk); #1; end

    // Four back-to-back items.
    cfg_len = 8'd4;
    send(1, 2, 0); send(3, -4, 0); send(-5, 6, 0); send(7, 8, 0);
    idle();
    check("len4_rdy_low", 64'(res_rdy), 64'd0);
    check("len4_val", 64'(acc_val), 64'd1);
    check("len4_sum", 64'(acc_data), 64'({26'(6), 26'(12)}));
    repeat (3) begin @(posedge clk); #1; end

    // Output back-pressure: nothing accepted while the result waits.
    sink_force = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    cfg_len = 8'd3;
    send(10, 20, 0); send(-30, 40, 1); send(50, -60, 0);
    res_data = {18'(77), 18'(88)};
    check("hold_val", 64'(acc_val), 64'd1);
    held = acc_data;
    repeat (10) begin
      @(negedge clk);
      check("hold_rdy_low", 64'(res_rdy), 64'd0);
      check("hold_stable", 64'(acc_data), 64'(held));
    end
    @(posedge clk); #1;
    idle();
    sink_force = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    // Worst-case magnitude over a full 255-item frame with gaps.
    cfg_len = 8'd255;
    for (int i = 0; i < 255; i++) send(32640, -32768, int'($urandom_range(0, 1)));
    idle();
    check("max_sum", 64'(acc_data), 64'({26'(8323200), 26'(-8355840)}));
    repeat (3) begin @(posedge clk); #1; end

    // Software reset mid-frame discards the partial sum.
    cfg_len = 8'd4;
    send(9, 9, 0); send(9, 9, 0);
    idle();
    check("busy_mid", 64'(acc_busy), 64'd1);
    do_swrst();
    check("busy_after_swrst", 64'(acc_busy), 64'd0);
    for (int i = 0; i < 4; i++) send(1, 1, 0);
    idle();
    check("swrst_sum", 64'(acc_data), 64'({26'(4), 26'(4)}));
    repeat (3) begin @(posedge clk); #1; end

    // Software reset while a result is pending drops it.
    sink_force = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    cfg_len = 8'd1;
    send(5, 5, 0);
    idle();
    repeat (2) begin @(posedge clk); #1; end
    do_swrst();
    void'(exp_q.pop_back());
    check("swrst_out_val", 64'(acc_val), 64'd0);
    check("swrst_out_rdy", 64'(res_rdy), 64'd1);
    sink_force = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Length zero behaves as one; mid-frame length edits are ignored.
    cfg_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      send(i + 1, -i, 0);
      check("len0_val", 64'(acc_val), 64'd1);
    end
    idle();
    repeat (2) begin @(posedge clk); #1; end
    cfg_len = 8'd2;
    send(11, 12, 0);
    cfg_len = 8'd5;
    send(13, 14, 0);
    idle();
    check("cfg_change_val", 64'(acc_val), 64'd1);
    repeat (3) begin @(posedge clk); #1; end

    // Randomized frames with random gaps and output back-pressure.
    sink_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      cfg_len = LW'($urandom_range(0, 6));
      n = (cfg_len == 0) ? 1 : int'(cfg_len);
      for (int i = 0; i < n; i++)
        send(int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 262143)) - 131072,
             int'($urandom_range(0, 2)));
    end
    idle();
    sink_rand = 1'b0;
    sink_force = 1'b1;

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
